// File: rtl/irrigation_timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irrigation_timer_ctrl_pkg
//  Purpose  : Shared types and constants for the irrigation watering timer:
//             FSM state encoding, BCD digit width/limit and the load clamp.
//  Revision : 1.0  initial release
// ============================================================================
package irrigation_timer_ctrl_pkg;

    localparam int                BCD_W   = 4;
    localparam logic [BCD_W-1:0]  BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Any non-BCD code on a load input is treated as the largest digit.
    function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irrigation_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : irrigation_timer_ctrl_if
//  Purpose  : Bundle between the irrigation FSM / display (master) and the
//             watering timer (slave).
//  Signals  : start, abort, load_tens, load_units, pause (TIMER_PAUSE_EN only)
//             master -> slave; valve, busy, done, tens, units slave -> master.
//  Config   : TIMER_PAUSE_EN adds the pause signal.
//  Revision : 1.0  initial release
// ============================================================================
interface irrigation_timer_ctrl_if;
    import irrigation_timer_ctrl_pkg::*;

    logic             start;
    logic             abort;
    logic [BCD_W-1:0] load_tens;
    logic [BCD_W-1:0] load_units;
`ifdef TIMER_PAUSE_EN
    logic             pause;
`endif
    logic             valve;
    logic             busy;
    logic             done;
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;

    modport master (
`ifdef TIMER_PAUSE_EN
        output pause,
`endif
        output start, abort, load_tens, load_units,
        input  valve, busy, done, tens, units
    );

    modport slave (
`ifdef TIMER_PAUSE_EN
        input  pause,
`endif
        input  start, abort, load_tens, load_units,
        output valve, busy, done, tens, units
    );
endinterface
`default_nettype wire

// File: rtl/irrigation_timer_ctrl_bcd_down_digit.sv
`default_nettype none
// ============================================================================
//  Module   : irrigation_timer_ctrl_bcd_down_digit
//  Purpose  : One loadable BCD down-counting digit. Decrementing from 0
//             wraps to 9 and raises borrow in the same cycle, so digits
//             chain by feeding borrow into the next digit's dec_en.
//  Ports    : clk, clear (async active-low), load, load_val, dec_en,
//             digit (registered), borrow (combinational).
//  Revision : 1.0  initial release
// ============================================================================
module irrigation_timer_ctrl_bcd_down_digit
    import irrigation_timer_ctrl_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             clear,
    input  wire logic             load,
    input  wire logic [BCD_W-1:0] load_val,
    input  wire logic             dec_en,
    output logic      [BCD_W-1:0] digit,
    output logic                  borrow
);
    logic [BCD_W-1:0] r_digit;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_digit <= '0;
        end else if (load) begin
            r_digit <= load_val;
        end else if (dec_en) begin
            r_digit <= (r_digit == '0) ? BCD_MAX : r_digit - 1'b1;
        end
    end

    assign digit  = r_digit;
    assign borrow = dec_en && (r_digit == '0);
endmodule
`default_nettype wire

// File: rtl/irrigation_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irrigation_timer_ctrl
//  Purpose  : Watering-duration sequencer. Loads a two-digit BCD duration,
//             divides clk into countdown ticks, counts down to 00 and drives
//             the valve, reporting busy and a one-cycle done pulse.
//  Params   : TICK_DIV - clk cycles per countdown tick (>= 2)
//  Ports    : clk, clear (async active-low reset), bus (slave modport:
//             start/abort/load digits in, valve/busy/done/tens/units out)
//  Config   : TIMER_PAUSE_EN enables pause and the PAUSED state.
//  Revision : 1.0  initial release
// ============================================================================
module irrigation_timer_ctrl
    import irrigation_timer_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50
) (
    input  wire logic               clk,
    input  wire logic               clear,
    irrigation_timer_ctrl_if.slave  bus
);
    localparam int                    c_PRESC_W   = $clog2(TICK_DIV);
    localparam logic [c_PRESC_W-1:0]  c_PRESC_MAX = c_PRESC_W'(TICK_DIV - 1);

    state_t                r_state;
    logic [c_PRESC_W-1:0]  r_presc;
    logic                  r_valve;
    logic                  r_busy;
    logic                  r_done;

    logic [BCD_W-1:0]      w_ld_tens;
    logic [BCD_W-1:0]      w_ld_units;
    logic [BCD_W-1:0]      w_tens;
    logic [BCD_W-1:0]      w_units;
    logic                  w_load;
    logic                  w_tick;
    logic                  w_units_borrow;
    logic                  w_tens_borrow;
    logic                  w_end;

    assign w_ld_tens  = clamp_bcd(bus.load_tens);
    assign w_ld_units = clamp_bcd(bus.load_units);

    // abort beats a simultaneous start in IDLE
    assign w_load = (r_state == ST_IDLE) && bus.start && !bus.abort;
    // abort also suppresses a coinciding tick so the digits hold their value
    assign w_tick = (r_state == ST_RUN) && (r_presc == c_PRESC_MAX) && !bus.abort;

    // The count reaches 00 exactly when a tick hits 01. A tens borrow would
    // mean wrapping below 00; it is folded in so such a state can only end.
    assign w_end = (w_tick && (w_tens == '0) && (w_units == 4'd1)) || w_tens_borrow;

    irrigation_timer_ctrl_bcd_down_digit u_units (
        .clk      (clk),
        .clear    (clear),
        .load     (w_load),
        .load_val (w_ld_units),
        .dec_en   (w_tick),
        .digit    (w_units),
        .borrow   (w_units_borrow)
    );

    irrigation_timer_ctrl_bcd_down_digit u_tens (
        .clk      (clk),
        .clear    (clear),
        .load     (w_load),
        .load_val (w_ld_tens),
        .dec_en   (w_units_borrow),
        .digit    (w_tens),
        .borrow   (w_tens_borrow)
    );

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_valve <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_presc <= '0;
                        if ((w_ld_tens != '0) || (w_ld_units != '0)) begin
                            r_state <= ST_RUN;
                            r_valve <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                        r_valve <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        // The cycle just ending was valve-on, so the prescaler
                        // advances even on the edge that enters PAUSED.
                        r_presc <= (r_presc == c_PRESC_MAX) ? '0 : r_presc + 1'b1;
                        if (w_end) begin
                            r_state <= ST_DONE;
                            r_valve <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
`ifdef TIMER_PAUSE_EN
                        else if (bus.pause) begin
                            r_state <= ST_PAUSED;
                            r_valve <= 1'b0;
                        end
`endif
                    end
                end

`ifdef TIMER_PAUSE_EN
                ST_PAUSED: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!bus.pause) begin
                        r_state <= ST_RUN;
                        r_valve <= 1'b1;
                    end
                end
`endif

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_valve <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.valve = r_valve;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.tens  = w_tens;
    assign bus.units = w_units;
endmodule
`default_nettype wire

// File: tb/tb_irrigation_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irrigation_timer_ctrl
//  Purpose  : Directed self-checking bench for irrigation_timer_ctrl with
//             TICK_DIV = 4. Inputs change and outputs are sampled on the
//             falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_irrigation_timer_ctrl;
    logic clk;
    logic clear;
    int   n_cmp;
    int   n_err;
    int   vc;
    int   dc;

    irrigation_timer_ctrl_if itf ();

    irrigation_timer_ctrl #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (itf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the
    // capturing rising edge (sample index k = 0 of the run).
    task automatic start_run(input logic [3:0] t, input logic [3:0] u);
        itf.start      = 1'b1;
        itf.load_tens  = t;
        itf.load_units = u;
        @(negedge clk);
        itf.start      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear = 1'b0;
        itf.start = 1'b0;
        itf.abort = 1'b0;
        itf.load_tens = 4'd0;
        itf.load_units = 4'd0;
`ifdef TIMER_PAUSE_EN
        itf.pause = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_valve", itf.valve, 0);
        chk("rst_busy",  itf.busy,  0);
        chk("rst_done",  itf.done,  0);
        chk("rst_tens",  itf.tens,  0);
        chk("rst_units", itf.units, 0);
        clear = 1'b1;
        @(negedge clk);

        // 0/3: 12 valve cycles, units step 3,2,1,0
        start_run(4'd0, 4'd3);
        chk("r03_busy", itf.busy, 1);
        vc = 0; dc = 0;
        for (int k = 0; k < 16; k++) begin
            if (k % 4 == 0 && k <= 12) chk($sformatf("r03_units_k%0d", k), itf.units, 3 - k / 4);
            if (k == 12) chk("r03_done_k12", itf.done, 1);
            if (itf.valve) vc++;
            if (itf.done) dc++;
            @(negedge clk);
        end
        chk("r03_valve_cycles", vc, 12);
        chk("r03_done_count", dc, 1);
        chk("r03_idle_busy", itf.busy, 0);

        // 1/0: first tick borrows to 09, 40 valve cycles
        start_run(4'd1, 4'd0);
        vc = 0; dc = 0;
        for (int k = 0; k < 50; k++) begin
            if (k == 0) chk("r10_tens_k0", itf.tens, 1);
            if (k == 4) begin
                chk("r10_tens_k4", itf.tens, 0);
                chk("r10_units_k4", itf.units, 9);
            end
            if (itf.valve) vc++;
            if (itf.done) dc++;
            @(negedge clk);
        end
        chk("r10_valve_cycles", vc, 40);
        chk("r10_done_count", dc, 1);
        chk("r10_final", {itf.tens, itf.units}, 8'h00);

        // 0/0: straight to DONE, valve never opens
        start_run(4'd0, 4'd0);
        chk("r00_done_k0", itf.done, 1);
        chk("r00_busy_k0", itf.busy, 0);
        vc = 0; dc = 0;
        for (int k = 0; k < 6; k++) begin
            if (itf.valve) vc++;
            if (itf.done) dc++;
            @(negedge clk);
        end
        chk("r00_valve_cycles", vc, 0);
        chk("r00_done_count", dc, 1);

        // 0/C clamps to 09, then abort; then start+abort together in IDLE
        start_run(4'd0, 4'hC);
        chk("clamp_units", itf.units, 9);
        chk("clamp_valve", itf.valve, 1);
        itf.abort = 1'b1;
        @(negedge clk);
        itf.abort = 1'b0;
        chk("abort_busy", itf.busy, 0);
        chk("abort_hold_units", itf.units, 9);
        itf.start = 1'b1; itf.abort = 1'b1; itf.load_units = 4'd5;
        @(negedge clk);
        itf.start = 1'b0; itf.abort = 1'b0;
        chk("sa_busy", itf.busy, 0);
        chk("sa_units", itf.units, 9);

        // 0/3 with start-while-busy at k=2 and abort at k=6
        start_run(4'd0, 4'd3);
        dc = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) begin itf.start = 1'b1; itf.load_units = 4'd7; end
            if (k == 3) begin
                itf.start = 1'b0;
                chk("busy_start_units", itf.units, 3);
            end
            if (k == 4) chk("busy_start_tick", itf.units, 2);
            if (k == 6) itf.abort = 1'b1;
            if (k == 7) begin
                itf.abort = 1'b0;
                chk("ab6_valve", itf.valve, 0);
                chk("ab6_busy", itf.busy, 0);
                chk("ab6_units", itf.units, 2);
            end
            if (itf.done) dc++;
            @(negedge clk);
        end
        chk("ab6_no_done", dc, 0);

        // async clear between edges mid-run
        start_run(4'd0, 4'd3);
        repeat (5) @(negedge clk);
        #2 clear = 1'b0;
        #1;
        chk("clr_valve", itf.valve, 0);
        chk("clr_busy", itf.busy, 0);
        chk("clr_digits", {itf.tens, itf.units}, 8'h00);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        start_run(4'd0, 4'd2);
        vc = 0; dc = 0;
        for (int k = 0; k < 12; k++) begin
            if (itf.valve) vc++;
            if (itf.done) dc++;
            @(negedge clk);
        end
        chk("clr_rerun_valve", vc, 8);
        chk("clr_rerun_done", dc, 1);

`ifdef TIMER_PAUSE_EN
        // pause 5 cycles mid-run; valve-on total unchanged
        start_run(4'd0, 4'd3);
        vc = 0; dc = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 2) itf.pause = 1'b1;
            if (k == 6) begin
                chk("pause_valve", itf.valve, 0);
                chk("pause_busy", itf.busy, 1);
                chk("pause_units", itf.units, 3);
            end
            if (k == 7) itf.pause = 1'b0;
            if (itf.valve) vc++;
            if (itf.done) dc++;
            @(negedge clk);
        end
        chk("pause_valve_cycles", vc, 12);
        chk("pause_done_count", dc, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
